// File: rtl/bitonic_pkg.sv
// Shared types and constants for the bitonic sorter merge stages.
// Merge-level index pairs are listed as lo/hi lanes, entry k feeding comparator k.
package bitonic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int N          = 8;
  localparam int NCMP       = N / 2;

  typedef enum logic [2:0] {
    IDLE,
    MRG1,
    MRG2,
    MRG3,
    DRAIN
  } state_e;

  typedef logic [NCMP-1:0][2:0] perm_t;

  localparam perm_t M1_LO = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam perm_t M1_HI = {3'd7, 3'd6, 3'd5, 3'd4};
  localparam perm_t M2_LO = {3'd5, 3'd4, 3'd1, 3'd0};
  localparam perm_t M2_HI = {3'd7, 3'd6, 3'd3, 3'd2};
  localparam perm_t M3_LO = {3'd6, 3'd4, 3'd2, 3'd0};
  localparam perm_t M3_HI = {3'd7, 3'd5, 3'd3, 3'd1};

endpackage

// File: rtl/bitonic_cmp_swap.sv
// Two-input unsigned compare-and-swap; ties pass through unswapped.
module bitonic_cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic swap;

  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_s3_stream.sv
// Stage-3 bitonic merge: three sequential CAS levels, then a one-per-cycle drain.
// Define BITONIC_S3_DESCEND_EN to stream the sorted set largest first.
module bitonic_s3_stream
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] number_in1,
  input  logic [DATA_W-1:0] number_in2,
  input  logic [DATA_W-1:0] number_in3,
  input  logic [DATA_W-1:0] number_in4,
  input  logic [DATA_W-1:0] number_in5,
  input  logic [DATA_W-1:0] number_in6,
  input  logic [DATA_W-1:0] number_in7,
  input  logic [DATA_W-1:0] number_in8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] number_out,
  output logic [2:0]        out_idx,
  output logic              out_last
);

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [N-1:0][DATA_W-1:0] v_q, v_d;

  perm_t lo_sel, hi_sel;
  logic merging;
  logic [NCMP-1:0][DATA_W-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;

  always_comb begin
    lo_sel  = M1_LO;
    hi_sel  = M1_HI;
    merging = 1'b0;
    unique case (1'b1)
      (state_q == MRG1): begin
        lo_sel  = M1_LO;
        hi_sel  = M1_HI;
        merging = 1'b1;
      end
      (state_q == MRG2): begin
        lo_sel  = M2_LO;
        hi_sel  = M2_HI;
        merging = 1'b1;
      end
      (state_q == MRG3): begin
        lo_sel  = M3_LO;
        hi_sel  = M3_HI;
        merging = 1'b1;
      end
      default: ;
    endcase
    for (int k = 0; k < NCMP; k++) begin
      cmp_a[k] = v_q[lo_sel[k]];
      cmp_b[k] = v_q[hi_sel[k]];
    end
  end

  for (genvar g = 0; g < NCMP; g++) begin : g_cmp
    bitonic_cmp_swap #(.DATA_W(DATA_W)) u_cas (
      .a  (cmp_a[g]),
      .b  (cmp_b[g]),
      .lo (cmp_lo[g]),
      .hi (cmp_hi[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          v_d = {number_in8, number_in7, number_in6, number_in5,
                 number_in4, number_in3, number_in2, number_in1};
          state_d = MRG1;
        end
      end
      MRG1: state_d = MRG2;
      MRG2: state_d = MRG3;
      MRG3: begin
        state_d = DRAIN;
        cnt_d   = 3'd0;
      end
      DRAIN: begin
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (merging) begin
      for (int k = 0; k < NCMP; k++) begin
        v_d[lo_sel[k]] = cmp_lo[k];
        v_d[hi_sel[k]] = cmp_hi[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
    end
  end

  logic       drain;
  logic [2:0] rd_idx;

`ifdef BITONIC_S3_DESCEND_EN
  assign rd_idx = 3'd7 - cnt_q;
`else
  assign rd_idx = cnt_q;
`endif

  assign drain      = (state_q == DRAIN);
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = drain;
  assign number_out = drain ? v_q[rd_idx] : '0;
  assign out_idx    = drain ? cnt_q : 3'd0;
  assign out_last   = drain && (cnt_q == 3'd7);

endmodule
